// File: rtl/memory_stage_hs.sv
// Memory stage with a valid/ready data-memory port. It holds one instruction,
// issues at most one aligned load or store for it, and returns the load or ALU result.
package memory_stage_hs_pkg;
  typedef struct packed {
    logic [2:0] funct3;
    logic       dmem_r_v;
    logic       dmem_w_v;
    logic       jmp_v;
    logic       br_v;
  } rvga_cword;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;
endpackage

// Handshake: the request transfers on a rising edge where dmem_req_v_o and
// dmem_req_ready_i are both 1. Once it is raised, dmem_req_v_o and its address,
// data and mask stay unchanged until that edge. A response is taken only in WAIT.
module memory_stage_hs
  import memory_stage_hs_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   v_i,
  input  logic                   stall_v_i,
  input  rvga_cword              cword_i,
  input  logic [width_p-1:0]     alu_result_i,
  input  logic                   bru_result_i,
  input  logic [width_p-1:0]     st_data_i,
  output logic                   dmem_req_v_o,
  input  logic                   dmem_req_ready_i,
  output logic                   dmem_we_o,
  output logic [width_p-1:0]     dmem_addr_o,
  output logic [width_p-1:0]     dmem_data_o,
  output logic [width_p/8-1:0]   dmem_wmask_o,
  input  logic                   dmem_resp_v_i,
  input  logic [width_p-1:0]     dmem_data_i,
  output logic                   mem_busy_o,
  output logic                   misalign_o,
  output logic                   result_v_o,
  output logic [width_p-1:0]     alu_or_ld_result_o,
  output logic                   btaken_o,
  output logic                   br_v_o,
  output mem_state_e             state_o
);
  localparam int bytes_lp  = width_p / 8;
  localparam int offset_lp = $clog2(bytes_lp);

  mem_state_e            state, state_n;
  logic                  v_r;
  rvga_cword             cword_r;
  logic [width_p-1:0]    alu_r;
  logic                  bru_r;
  logic [width_p-1:0]    st_r;
  logic [width_p-1:0]    ld_r;

  logic                  cap;
  logic                  go_req;
  logic                  is_mem_r;
  logic                  is_store_r;
  logic                  is_load_r;
  logic                  access_ok_r;
  logic                  req_act;
  logic [offset_lp-1:0]  off_r;
  logic [bytes_lp-1:0]   size_run;
  logic [width_p-1:0]    st_shift;

  // Illegal funct3 for this width is reported the same way as a misaligned access.
  function automatic logic access_ok(logic is_st, logic [2:0] f3, logic [offset_lp-1:0] off);
    logic legal;
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < offset_lp; i++)
      if (i < int'(f3[1:0])) bad = bad | off[i];
    if (is_st) begin
      legal = ~f3[2] & ((f3[1:0] != 2'b11) | (width_p == 64));
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (width_p == 64);
        default:                                legal = 1'b0;
      endcase
    end
    return legal & ~bad;
  endfunction

  function automatic logic [width_p-1:0] load_ext(logic [width_p-1:0] word, logic [2:0] f3,
                                                  logic [offset_lp-1:0] off);
    logic [width_p-1:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return width_p'($signed(sh[7:0]));
      3'b001:  return width_p'($signed(sh[15:0]));
      3'b010:  return width_p'($signed(sh[31:0]));
      3'b100:  return width_p'(sh[7:0]);
      3'b101:  return width_p'(sh[15:0]);
      3'b110:  return width_p'(sh[31:0]);
      default: return sh;
    endcase
  endfunction

  assign mem_busy_o = (state == REQ) | (state == WAIT);
  assign cap        = ~stall_v_i & ~mem_busy_o;
  assign go_req     = v_i & (cword_i.dmem_r_v | cword_i.dmem_w_v)
                    & access_ok(cword_i.dmem_w_v, cword_i.funct3, alu_result_i[offset_lp-1:0]);

  assign off_r       = alu_r[offset_lp-1:0];
  assign is_mem_r    = cword_r.dmem_r_v | cword_r.dmem_w_v;
  assign is_store_r  = cword_r.dmem_w_v;
  assign is_load_r   = cword_r.dmem_r_v & ~cword_r.dmem_w_v;
  assign access_ok_r = access_ok(is_store_r, cword_r.funct3, off_r);

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (cap) state_n = go_req ? REQ : IDLE;
      REQ:        if (dmem_req_ready_i) state_n = WAIT;
      WAIT:       if (dmem_resp_v_i) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      v_r     <= 1'b0;
      cword_r <= '0;
      alu_r   <= '0;
      bru_r   <= 1'b0;
      st_r    <= '0;
      ld_r    <= '0;
    end else begin
      state <= state_n;
      if (cap) begin
        v_r     <= v_i;
        cword_r <= cword_i;
        alu_r   <= alu_result_i;
        bru_r   <= bru_result_i;
        st_r    <= st_data_i;
      end
      if ((state == WAIT) && dmem_resp_v_i && is_load_r)
        ld_r <= load_ext(dmem_data_i, cword_r.funct3, off_r);
    end
  end

  // Byte-enable run of access size, later shifted into the addressed lanes.
  always_comb begin
    int run_len;
    size_run = '0;
    run_len  = 1 << cword_r.funct3[1:0];
    for (int i = 0; i < bytes_lp; i++)
      size_run[i] = (i < run_len);
  end

  assign st_shift = st_r << {off_r, 3'b000};
  assign req_act  = (state == REQ);

  assign dmem_req_v_o = req_act;
  assign dmem_we_o    = req_act & is_store_r;
  assign dmem_addr_o  = req_act ? {alu_r[width_p-1:offset_lp], {offset_lp{1'b0}}} : '0;
  assign dmem_data_o  = (req_act & is_store_r) ? st_shift : '0;
  assign dmem_wmask_o = (req_act & is_store_r) ? (size_run << off_r) : '0;

  assign misalign_o         = v_r & is_mem_r & ~access_ok_r;
  assign result_v_o         = v_r & (((state == IDLE) & ~is_mem_r) | (state == DONE));
  assign alu_or_ld_result_o = ((state == DONE) & is_load_r) ? ld_r : alu_r;
  assign btaken_o           = v_r & (cword_r.jmp_v | (cword_r.br_v & bru_r));
  assign br_v_o             = v_r & (cword_r.jmp_v | cword_r.br_v);
  assign state_o            = state;
endmodule

// File: tb/tb_memory_stage_hs.sv
// Bench for memory_stage_hs: 32-bit instance for most scenarios, 64-bit instance
// for doubleword access; expectations come from an arithmetic load/store model.
module tb_memory_stage_hs;
  import memory_stage_hs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, v, stall, bru, ready, resp_v;
  rvga_cword   cword;
  logic [31:0] alu, st, rdata;
  logic        req_v, we, busy, misalign, res_v, btaken, br_v;
  logic [31:0] addr, wdata, res;
  logic [3:0]  wmask;
  mem_state_e  state;

  logic [63:0] alu_64, st_64, rdata_64;
  logic        req_v_64, we_64, busy_64, misalign_64, res_v_64, btaken_64, br_v_64;
  logic [63:0] addr_64, wdata_64, res_64;
  logic [7:0]  wmask_64;
  mem_state_e  state_64;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  memory_stage_hs #(.width_p(32)) dut (
    .clk_i(clk), .rst_i(rst), .v_i(v), .stall_v_i(stall), .cword_i(cword),
    .alu_result_i(alu), .bru_result_i(bru), .st_data_i(st),
    .dmem_req_v_o(req_v), .dmem_req_ready_i(ready), .dmem_we_o(we),
    .dmem_addr_o(addr), .dmem_data_o(wdata), .dmem_wmask_o(wmask),
    .dmem_resp_v_i(resp_v), .dmem_data_i(rdata), .mem_busy_o(busy),
    .misalign_o(misalign), .result_v_o(res_v), .alu_or_ld_result_o(res),
    .btaken_o(btaken), .br_v_o(br_v), .state_o(state)
  );

  memory_stage_hs #(.width_p(64)) dut_64 (
    .clk_i(clk), .rst_i(rst), .v_i(v), .stall_v_i(stall), .cword_i(cword),
    .alu_result_i(alu_64), .bru_result_i(bru), .st_data_i(st_64),
    .dmem_req_v_o(req_v_64), .dmem_req_ready_i(ready), .dmem_we_o(we_64),
    .dmem_addr_o(addr_64), .dmem_data_o(wdata_64), .dmem_wmask_o(wmask_64),
    .dmem_resp_v_i(resp_v), .dmem_data_i(rdata_64), .mem_busy_o(busy_64),
    .misalign_o(misalign_64), .result_v_o(res_v_64), .alu_or_ld_result_o(res_64),
    .btaken_o(btaken_64), .br_v_o(br_v_64), .state_o(state_64)
  );

  // Reference model: access legality, byte lanes and load extension by arithmetic.
  function automatic bit m_ok(bit is_st, logic [2:0] f3, longint unsigned a, int w);
    bit legal;
    longint unsigned sz;
    if (is_st) legal = (f3 <= 3'd2) || (w == 64 && f3 == 3'd3);
    else       legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (w == 64 && f3 inside {3'd3, 3'd6});
    sz = longint'(1) << f3[1:0];
    return legal && (a % sz == 0);
  endfunction

  function automatic int m_mask(logic [2:0] f3, longint unsigned a, int w);
    int off;
    off = int'(a % longint'(w / 8));
    return ((1 << (1 << f3[1:0])) - 1) << off;
  endfunction

  function automatic logic [63:0] m_sdata(logic [63:0] d, longint unsigned a, int w);
    int off;
    off = int'(a % longint'(w / 8));
    return d << (8 * off);
  endfunction

  function automatic logic [63:0] m_load(logic [2:0] f3, longint unsigned a, logic [63:0] word, int w);
    int off, nb;
    logic [63:0] val, m;
    off = int'(a % longint'(w / 8));
    nb  = 8 * (1 << f3[1:0]);
    val = word >> (8 * off);
    if (nb < 64) begin
      m   = (64'd1 << nb) - 64'd1;
      val = val & m;
      if (!f3[2] && val[nb-1]) val = val | ~m;
    end
    return val;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v = 1'b1; stall = 1'b0; bru = 1'b1; ready = 1'b1; resp_v = 1'b1;
    cword = 7'h7f; alu = $urandom; st = $urandom; rdata = $urandom;
    alu_64 = '0; st_64 = '0; rdata_64 = '0;
    tick(); tick();
    checks++;
    if ({req_v, we, addr, wdata, wmask, busy, misalign, res_v, res, btaken, br_v} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req_v=%b busy=%b res_v=%b res=%h br_v=%b exp all 0",
               req_v, busy, res_v, res, br_v);
    end
    checks++;
    if (state !== IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE);
    end
    rst = 1'b0; v = 1'b0; ready = 1'b0; resp_v = 1'b0; cword = '0; alu = '0; bru = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    logic j, b, bv, vv;
    logic [31:0] a;
    for (int i = 0; i < 12; i++) begin
      j = 1'($urandom); b = 1'($urandom); bv = 1'($urandom); vv = ($urandom_range(0, 3) != 0);
      a = $urandom;
      cword = '{funct3: 3'($urandom), dmem_r_v: 1'b0, dmem_w_v: 1'b0, jmp_v: j, br_v: b};
      v = vv; alu = a; bru = bv; stall = 1'b0;
      tick();
      checks++;
      if (res_v !== vv || misalign !== 1'b0) begin
        errors++; $display("FAIL alu_valid got res_v=%b misalign=%b exp res_v=%b misalign=0", res_v, misalign, vv);
      end
      checks++;
      if (btaken !== (vv & (j | (b & bv))) || br_v !== (vv & (j | b))) begin
        errors++; $display("FAIL alu_branch got btaken=%b br_v=%b exp %b %b",
                           btaken, br_v, vv & (j | (b & bv)), vv & (j | b));
      end
      if (vv) begin
        checks++;
        if (res !== a) begin
          errors++; $display("FAIL alu_result got=%h exp=%h", res, a);
        end
        stall = 1'b1; v = 1'b1; alu = ~a;
        cword = '{funct3: 3'd0, dmem_r_v: 1'b0, dmem_w_v: 1'b0, jmp_v: 1'b1, br_v: 1'b0};
        tick();
        checks++;
        if (res !== a || br_v !== (j | b)) begin
          errors++; $display("FAIL alu_stall_hold got res=%h br_v=%b exp res=%h br_v=%b", res, br_v, a, j | b);
        end
        stall = 1'b0;
      end
    end
    v = 1'b0; cword = '0; bru = 1'b0;
  endtask

  task automatic do_mem(input bit is_st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] word,
                        input int rdy_dly, input int rsp_dly,
                        output logic [31:0] got_res, output logic [31:0] got_data,
                        output logic [3:0] got_mask);
    bit ok;
    logic [31:0] e_res, e_data, e_pop;
    logic [3:0]  e_mask;
    ok     = m_ok(is_st, f3, a, 32);
    e_mask = 4'(m_mask(f3, a, 32));
    e_data = 32'(m_sdata({32'd0, sd}, a, 32));
    e_res  = is_st ? a : 32'(m_load(f3, a, {32'd0, word}, 32));
    got_res = '0; got_data = '0; got_mask = '0;
    stall = 1'b0; ready = 1'b0; resp_v = 1'b0;
    v = 1'b1; alu = a; st = sd;
    cword = '{funct3: f3, dmem_r_v: !is_st, dmem_w_v: is_st, jmp_v: 1'b0, br_v: 1'b0};
    tick();
    if (ok) begin
      exp_q.push_back(e_res);
      for (int k = 0; k <= rdy_dly; k++) begin
        checks++;
        if (req_v !== 1'b1 || addr !== {a[31:2], 2'b00} || we !== is_st || busy !== 1'b1) begin
          errors++; $display("FAIL req_hold got req_v=%b addr=%h we=%b busy=%b exp 1 %h %b 1",
                             req_v, addr, we, busy, {a[31:2], 2'b00}, is_st);
        end
        checks++;
        if (wmask !== (is_st ? e_mask : 4'b0000)) begin
          errors++; $display("FAIL req_wmask got=%b exp=%b", wmask, is_st ? e_mask : 4'b0000);
        end
        if (is_st) begin
          checks++;
          if (wdata !== e_data) begin
            errors++; $display("FAIL req_wdata got=%h exp=%h", wdata, e_data);
          end
        end
        if (k == 0) begin got_data = wdata; got_mask = wmask; end
        v = 1'($urandom); cword = 7'($urandom); alu = $urandom;
        stall = 1'($urandom); ready = (k == rdy_dly);
        tick();
      end
      ready = 1'b0;
      for (int k = 0; k <= rsp_dly; k++) begin
        checks++;
        if (state !== WAIT || busy !== 1'b1 || req_v !== 1'b0) begin
          errors++; $display("FAIL wait_state got state=%0d busy=%b req_v=%b exp %0d 1 0", state, busy, req_v, WAIT);
        end
        resp_v = (k == rsp_dly);
        rdata  = resp_v ? word : $urandom;
        stall  = 1'($urandom);
        tick();
      end
      resp_v = 1'b0; stall = 1'b0;
      checks++;
      if (state !== DONE || res_v !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL done_flags got state=%0d res_v=%b busy=%b exp %0d 1 0", state, res_v, busy, DONE);
      end
      got_res = res;
      e_pop = exp_q.pop_front();
      checks++;
      if (res !== e_pop) begin
        errors++; $display("FAIL mem_result got=%h exp=%h (f3=%0d addr=%h)", res, e_pop, f3, a);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (misalign !== 1'b1 || req_v !== 1'b0 || busy !== 1'b0 || res_v !== 1'b0) begin
          errors++; $display("FAIL misalign got misalign=%b req_v=%b busy=%b res_v=%b exp 1 0 0 0",
                             misalign, req_v, busy, res_v);
        end
        ready = 1'($urandom);
        tick();
      end
      ready = 1'b0;
    end
    v = 1'b0; cword = '0;
  endtask

  task automatic test_lw_timing();
    int busy_cnt;
    stall = 1'b0; v = 1'b1; alu = 32'h104;
    cword = '{funct3: 3'b010, dmem_r_v: 1'b1, dmem_w_v: 1'b0, jmp_v: 1'b0, br_v: 1'b0};
    tick();
    v = 1'b0; cword = '0; busy_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (busy) busy_cnt++;
      ready = (c == 0); resp_v = (c == 2); rdata = (c == 2) ? 32'hDEADBEEF : 32'h0;
      tick();
    end
    ready = 1'b0; resp_v = 1'b0;
    checks++;
    if (busy_cnt != 3 || busy !== 1'b0) begin
      errors++; $display("FAIL lw_busy_cycles got=%0d busy_now=%b exp=3 0", busy_cnt, busy);
    end
    checks++;
    if (res !== 32'hDEADBEEF || res_v !== 1'b1) begin
      errors++; $display("FAIL lw_result got=%h v=%b exp=deadbeef 1", res, res_v);
    end
    stall = 1'b1;
    tick();
    checks++;
    if (state !== DONE || res_v !== 1'b1 || res !== 32'hDEADBEEF) begin
      errors++; $display("FAIL done_hold got state=%0d res_v=%b res=%h exp %0d 1 deadbeef", state, res_v, res, DONE);
    end
    stall = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [31:0] r, d;
    logic [3:0]  m;
    do_mem(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, r, d, m);
    checks++;
    if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_vector got=%h exp=ffffff80", r); end
    do_mem(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0, r, d, m);
    checks++;
    if (r !== 32'h00000080) begin errors++; $display("FAIL lbu_vector got=%h exp=00000080", r); end
    do_mem(1'b1, 3'b001, 32'h102, 32'h1234, 32'h0, 0, 0, r, d, m);
    checks++;
    if (m !== 4'b1100 || d !== 32'h12340000) begin
      errors++; $display("FAIL sh_vector got mask=%b data=%h exp 1100 12340000", m, d);
    end
    do_mem(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, r, d, m);
    do_mem(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, r, d, m);
    do_mem(1'b0, 3'b010, 32'h200, 32'h0, 32'h55AA33CC, 4, 2, r, d, m);
  endtask

  task automatic test_random();
    logic [31:0] a, r, d;
    logic [3:0]  m;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_mem(1'($urandom), 3'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), r, d, m);
    end
  endtask

  task automatic test_reset_in_wait();
    v = 1'b1; alu = 32'h40; stall = 1'b0;
    cword = '{funct3: 3'b010, dmem_r_v: 1'b1, dmem_w_v: 1'b0, jmp_v: 1'b0, br_v: 1'b0};
    tick();
    v = 1'b0; alu = '0; cword = '0; ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (state !== WAIT) begin errors++; $display("FAIL rst_wait_entry got=%0d exp=%0d", state, WAIT); end
    rst = 1'b1; resp_v = 1'b1; rdata = 32'hCAFEF00D;
    tick();
    rst = 1'b0; resp_v = 1'b0;
    checks++;
    if (state !== IDLE || {req_v, we, addr, wdata, wmask, busy, misalign, res_v, res, btaken, br_v} !== '0) begin
      errors++; $display("FAIL rst_in_wait got state=%0d busy=%b res_v=%b res=%h exp 0 0 0 0", state, busy, res_v, res);
    end
    tick();
    checks++;
    if (res_v !== 1'b0 || res !== 32'h0) begin
      errors++; $display("FAIL rst_resp_discard got res_v=%b res=%h exp 0 0", res_v, res);
    end
  endtask

  task automatic test_ld64();
    logic [2:0]  f3s[4]   = '{3'b011, 3'b110, 3'b010, 3'b011};
    logic [63:0] addrs[4] = '{64'h8, 64'hC, 64'hC, 64'h10};
    bit          sts[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] word, sd, e_res, e_addr;
    logic [7:0]  e_mask;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word = (i == 0) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
      if (i > 0) word[63] = 1'b1;
      sd = {$urandom, $urandom};
      e_addr = {addrs[i][63:3], 3'b000};
      e_mask = sts[i] ? 8'(m_mask(f3s[i], addrs[i], 64)) : 8'h00;
      e_res  = sts[i] ? addrs[i] : m_load(f3s[i], addrs[i], word, 64);
      v = 1'b1; alu_64 = addrs[i]; st_64 = sd; stall = 1'b0;
      cword = '{funct3: f3s[i], dmem_r_v: !sts[i], dmem_w_v: sts[i], jmp_v: 1'b0, br_v: 1'b0};
      tick();
      v = 1'b0; cword = '0;
      checks++;
      if (req_v_64 !== 1'b1 || addr_64 !== e_addr || wmask_64 !== e_mask || we_64 !== sts[i]) begin
        errors++; $display("FAIL req64 got v=%b addr=%h mask=%b we=%b exp 1 %h %b %b",
                           req_v_64, addr_64, wmask_64, we_64, e_addr, e_mask, sts[i]);
      end
      if (sts[i]) begin
        checks++;
        if (wdata_64 !== sd) begin errors++; $display("FAIL sd64_data got=%h exp=%h", wdata_64, sd); end
      end
      ready = 1'b1; tick(); ready = 1'b0;
      resp_v = 1'b1; rdata_64 = word; tick(); resp_v = 1'b0;
      checks++;
      if (res_v_64 !== 1'b1 || res_64 !== e_res) begin
        errors++; $display("FAIL result64 got v=%b res=%h exp 1 %h", res_v_64, res_64, e_res);
      end
      if (i == 0) begin
        checks++;
        if (res_64 !== 64'h0123456789ABCDEF) begin
          errors++; $display("FAIL ld64_vector got=%h exp=0123456789abcdef", res_64);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_timing();
    test_spec_vectors();
    test_random();
    test_reset_in_wait();
    test_ld64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_stage_hs.md
MEMORY_STAGE_HS -- requirements
Module: memory_stage_hs

Interface
REQ-001 Parameter width_p, default 32, datapath/word width in bits; legal values 32 or 64.
REQ-002 Parameter derived bytes_lp = width_p/8; offset_lp = log2(bytes_lp).
REQ-003 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 v_i  in  1  upstream instruction valid.
REQ-006 stall_v_i  in  1  global stall; blocks capture of a new instruction.
REQ-007 cword_i  in  rvga_cword  control word; fields used: funct3, dmem_r_v, dmem_w_v, jmp_v, br_v.
REQ-008 alu_result_i  in  width_p  effective address or ALU result.
REQ-009 bru_result_i  in  1  branch condition.
REQ-010 st_data_i  in  width_p  store data, right-aligned.
REQ-011 dmem_req_v_o / dmem_req_ready_i  out/in  1/1  request valid/ready handshake.
REQ-012 dmem_we_o  out  1  1 = store, 0 = load.
REQ-013 dmem_addr_o  out  width_p  word-aligned address (low offset_lp bits forced 0).
REQ-014 dmem_data_o  out  width_p  store data shifted into byte lanes.
REQ-015 dmem_wmask_o  out  bytes_lp  byte write enables; all zero for loads.
REQ-016 dmem_resp_v_i / dmem_data_i  in  1/width_p  response valid and read word.
REQ-017 mem_busy_o  out  1  stage stall request to upstream.
REQ-018 misalign_o  out  1  held instruction is a misaligned memory access.
REQ-019 result_v_o  out  1  alu_or_ld_result_o is valid.
REQ-020 alu_or_ld_result_o  out  width_p  load result (loads) else registered ALU result.
REQ-021 btaken_o / br_v_o  out  1/1  branch taken / control-transfer instruction.

Function
REQ-022 Capture enable cap = ~stall_v_i & ~mem_busy_o; on cap, v_i, cword_i, alu_result_i, bru_result_i, st_data_i SHALL load into the stage register.
REQ-023 FSM states IDLE, REQ, WAIT, DONE; mem_busy_o = (state==REQ | state==WAIT).
REQ-024 On cap: valid aligned memory op -> REQ; anything else -> IDLE.
REQ-025 REQ: dmem_req_v_o=1 with dmem_we_o/addr/data/wmask stable; on dmem_req_ready_i -> WAIT.
REQ-026 WAIT: dmem_resp_v_i ignored in REQ; on dmem_resp_v_i load data latched (stores ignore data) -> DONE.
REQ-027 DONE: result held; remains DONE until next cap.
REQ-028 result_v_o = valid & ((IDLE & non-memory op) | DONE).
REQ-029 Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; width_p=64 also 011 LD, 110 LWU; sign/zero extension to width_p.
REQ-030 Store funct3: 000 SB, 001 SH, 010 SW, 011 SD (64 only); wmask = size-bit run shifted by addr[offset_lp-1:0].
REQ-031 Misaligned = address offset not multiple of access size; illegal funct3 for width_p treated as misaligned; misalign_o=1, no request issued, result_v_o=0.
REQ-032 btaken_o = valid & (jmp_v | (br_v & bru_result)); br_v_o = valid & (jmp_v | br_v); both from stage register.
REQ-033 stall_v_i during WAIT/REQ SHALL NOT drop an issued request; dmem_req_v_o never retracts before ready.

Reset
REQ-034 rst_i high at clock edge: state IDLE, all stage registers zero, all outputs zero, overriding any outstanding request or response.
REQ-035 Response arriving the cycle rst_i is asserted SHALL be discarded.

Verification
REQ-036 LW addr 0x104, ready=1 immediately, resp 2 cycles later data 0xDEADBEEF -> busy high 3 cycles, result 0xDEADBEEF, result_v 1.
REQ-037 LB addr 0x103, read word 0x80FFFFFF -> result 0xFFFFFF80; LBU -> 0x00000080.
REQ-038 SH addr 0x102, st_data 0x1234 -> wmask 1100, dmem_data 0x12340000, we 1.
REQ-039 LW addr 0x102 -> misalign_o 1, dmem_req_v_o 0 every cycle, busy 0.
REQ-040 ready held 0 for 4 cycles with stall_v_i toggling -> req_v/addr stable, no new capture.
REQ-041 rst_i in WAIT, resp_v same cycle -> next cycle IDLE, all outputs 0; width_p=64 LD addr 0x8 returns full word.
